// File: rtl/axi_riscv_amo_pkg.sv
// Shared types for the RISC-V atomics AXI initiator.
//   amo_op_e     : request opcode (LR, SC and the nine AMOs)
//   state_e      : initiator FSM states
//   ATOP_*       : AXI5 AWATOP encodings (little-endian AtomicLoad/AtomicSwap)
//   RESP_*       : AXI xRESP codes
//   atop_of()    : opcode -> AWATOP, 0 for LR/SC
//   resp_is_err(): SLVERR/DECERR detection
package axi_riscv_amo_pkg;

  typedef enum logic [3:0] {
    AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND,
    AMO_OR, AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU
  } amo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AR, ST_R_WAIT, ST_AW_W, ST_RESP_WAIT, ST_RSP
  } state_e;

  localparam logic [5:0] ATOP_NONE = 6'b000000;
  localparam logic [5:0] ATOP_SWAP = 6'b110000;
  localparam logic [5:0] ATOP_ADD  = 6'b100000;
  localparam logic [5:0] ATOP_CLR  = 6'b100001;
  localparam logic [5:0] ATOP_EOR  = 6'b100010;
  localparam logic [5:0] ATOP_SET  = 6'b100011;
  localparam logic [5:0] ATOP_SMAX = 6'b100100;
  localparam logic [5:0] ATOP_SMIN = 6'b100101;
  localparam logic [5:0] ATOP_UMAX = 6'b100110;
  localparam logic [5:0] ATOP_UMIN = 6'b100111;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [5:0] atop_of(amo_op_e op);
    case (op)
      AMO_SWAP: return ATOP_SWAP;
      AMO_ADD:  return ATOP_ADD;
      AMO_AND:  return ATOP_CLR;  // AND is issued as CLR of the inverted operand
      AMO_XOR:  return ATOP_EOR;
      AMO_OR:   return ATOP_SET;
      AMO_MIN:  return ATOP_SMIN;
      AMO_MAX:  return ATOP_SMAX;
      AMO_MINU: return ATOP_UMIN;
      AMO_MAXU: return ATOP_UMAX;
      default:  return ATOP_NONE;
    endcase
  endfunction

  function automatic logic resp_is_err(logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_riscv_amo_master_if.sv
// AXI5 channel subset used by the atomics initiator (single-beat, ATOP capable).
//   master modport: drives AW/W/AR payload+valid, B/R ready
//   slave modport : drives AW/W/AR ready, B/R payload+valid
interface axi_riscv_amo_master_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 4,
  parameter int UserWidth = 1
);
  logic                   aw_valid, aw_ready, aw_lock;
  logic [AddrWidth-1:0]   aw_addr;
  logic [IdWidth-1:0]     aw_id;
  logic [7:0]             aw_len;
  logic [2:0]             aw_size;
  logic [1:0]             aw_burst;
  logic [5:0]             aw_atop;
  logic [UserWidth-1:0]   aw_user;
  logic                   w_valid, w_ready, w_last;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic [UserWidth-1:0]   w_user;
  logic                   b_valid, b_ready;
  logic [1:0]             b_resp;
  logic                   ar_valid, ar_ready, ar_lock;
  logic [AddrWidth-1:0]   ar_addr;
  logic [IdWidth-1:0]     ar_id;
  logic [7:0]             ar_len;
  logic [2:0]             ar_size;
  logic [1:0]             ar_burst;
  logic [UserWidth-1:0]   ar_user;
  logic                   r_valid, r_ready;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;

  modport master (
    output aw_valid, aw_lock, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_atop, aw_user,
    output w_valid, w_last, w_data, w_strb, w_user, b_ready,
    output ar_valid, ar_lock, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_user, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_lock, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_atop, aw_user,
    input  w_valid, w_last, w_data, w_strb, w_user, b_ready,
    input  ar_valid, ar_lock, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_user, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_riscv_amo_lane.sv
// Combinational byte-lane placement for the atomics initiator.
//   addr_lsb : byte offset within the data bus (address already aligned)
//   size_64  : 1 = 64-bit access, 0 = 32-bit access
//   wdata    : core-side store/operand word
//   r_bus    : raw R channel data
//   w_data/w_strb : W payload, operand replicated across the bus with strobes at the target lane
//   rdata    : lane-extracted load value, 32-bit accesses sign-extended to the core word
module axi_riscv_amo_lane #(
  parameter int AxiDataWidth   = 64,
  parameter int RiscvWordWidth = 64,
  parameter int AxiAddrLSB     = $clog2(AxiDataWidth/8)
) (
  input  logic [AxiAddrLSB-1:0]     addr_lsb,
  input  logic                      size_64,
  input  logic [RiscvWordWidth-1:0] wdata,
  input  logic [AxiDataWidth-1:0]   r_bus,
  output logic [AxiDataWidth-1:0]   w_data,
  output logic [AxiDataWidth/8-1:0] w_strb,
  output logic [RiscvWordWidth-1:0] rdata
);
  localparam int StrbWidth = AxiDataWidth / 8;

  // Work in a fixed 64-bit frame so 32- and 64-bit buses share one datapath.
  logic [2:0]  boff;
  logic [63:0] wd_ext, r_ext, r_sh;
  logic [7:0]  strb_full;

  always_comb begin
    boff   = 3'(addr_lsb);
    wd_ext = 64'(wdata);
    r_ext  = 64'(r_bus);
    r_sh   = r_ext >> {boff, 3'b000};
    if (size_64) begin
      w_data    = AxiDataWidth'({2{wd_ext}});
      strb_full = 8'hFF;
      rdata     = RiscvWordWidth'(r_sh);
    end else begin
      w_data    = AxiDataWidth'({4{wd_ext[31:0]}});
      strb_full = 8'h0F << boff;
      rdata     = RiscvWordWidth'({{32{r_sh[31]}}, r_sh[31:0]});
    end
    w_strb = StrbWidth'(strb_full);
  end
endmodule

// File: rtl/axi_riscv_amo_master.sv
// Core-side AXI initiator for RISC-V LR/SC/AMO. One transaction outstanding.
//   clk_i, rst_i (sync, active-high)
//   req_*  : valid/ready request (op, byte addr, size 0=32b/1=64b, wdata)
//   rsp_*  : valid/ready response (rdata, error); SC rdata 0=success, 1=fail
//   axi_mst: AXI5 master modport (exclusive AR for LR, exclusive AW+W for SC, AW+W+ATOP for AMO)
// Optional build macro AXI_RISCV_AMO_MASTER_ALIGN_CHECK_EN: misaligned requests skip the bus and
// respond with error=1, rdata=0. Without it low address bits are cleared and the access issued.
//
// state        | meaning
// ST_IDLE      | ready for a request
// ST_AR        | exclusive read address presented (LR)
// ST_R_WAIT    | waiting for the LR read beat
// ST_AW_W      | AW and W presented, each retired on its own ready
// ST_RESP_WAIT | collecting B (and R for AMOs) in any order
// ST_RSP       | response held until accepted
module axi_riscv_amo_master
  import axi_riscv_amo_pkg::*;
#(
  parameter int                      AxiAddrWidth   = 32,
  parameter int                      AxiDataWidth   = 64,
  parameter int                      AxiIdWidth     = 4,
  parameter int                      AxiUserWidth   = 1,
  parameter logic [AxiIdWidth-1:0]   AxiId          = '0,
  parameter logic [AxiUserWidth-1:0] AxiUser        = '0,
  parameter int                      RiscvWordWidth = 64,
  parameter int                      AxiAddrLSB     = $clog2(AxiDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  amo_op_e                   req_op_i,
  input  logic [AxiAddrWidth-1:0]   req_addr_i,
  input  logic                      req_size_i,
  input  logic [RiscvWordWidth-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RiscvWordWidth-1:0] rsp_rdata_o,
  output logic                      rsp_error_o,
  axi_riscv_amo_master_if.master    axi_mst
);
  state_e                    state_q, state_d;
  amo_op_e                   op_q;
  logic [AxiAddrWidth-1:0]   addr_q, req_addr_aligned;
  logic [RiscvWordWidth-1:0] wdata_q, operand, lane_rdata, rdata_q;
  logic                      size_q, err_q, misaligned, is_amo, b_hit, r_hit;
  logic                      aw_done_q, w_done_q, b_done_q, r_done_q;

  assign req_addr_aligned = req_addr_i & ~AxiAddrWidth'(req_size_i ? 3'd7 : 3'd3);
`ifdef AXI_RISCV_AMO_MASTER_ALIGN_CHECK_EN
  assign misaligned = (req_addr_i != req_addr_aligned);
`else
  assign misaligned = 1'b0;
`endif

  assign is_amo  = (op_q != AMO_LR) && (op_q != AMO_SC);
  assign operand = (op_q == AMO_AND) ? ~wdata_q : wdata_q;
  assign b_hit   = (state_q == ST_RESP_WAIT) && axi_mst.b_valid && !b_done_q;
  assign r_hit   = (state_q == ST_RESP_WAIT) && is_amo && axi_mst.r_valid && !r_done_q;

  axi_riscv_amo_lane #(
    .AxiDataWidth  (AxiDataWidth),
    .RiscvWordWidth(RiscvWordWidth),
    .AxiAddrLSB    (AxiAddrLSB)
  ) i_lane (
    .addr_lsb(addr_q[AxiAddrLSB-1:0]),
    .size_64 (size_q),
    .wdata   (operand),
    .r_bus   (axi_mst.r_data),
    .w_data  (axi_mst.w_data),
    .w_strb  (axi_mst.w_strb),
    .rdata   (lane_rdata)
  );

  assign axi_mst.aw_addr  = addr_q;
  assign axi_mst.aw_id    = AxiId;
  assign axi_mst.aw_len   = 8'd0;
  assign axi_mst.aw_size  = size_q ? 3'd3 : 3'd2;
  assign axi_mst.aw_burst = 2'b01;
  assign axi_mst.aw_lock  = (op_q == AMO_SC);
  assign axi_mst.aw_atop  = atop_of(op_q);
  assign axi_mst.aw_user  = AxiUser;
  assign axi_mst.w_last   = 1'b1;
  assign axi_mst.w_user   = AxiUser;
  assign axi_mst.ar_addr  = addr_q;
  assign axi_mst.ar_id    = AxiId;
  assign axi_mst.ar_len   = 8'd0;
  assign axi_mst.ar_size  = size_q ? 3'd3 : 3'd2;
  assign axi_mst.ar_burst = 2'b01;
  assign axi_mst.ar_lock  = 1'b1;
  assign axi_mst.ar_user  = AxiUser;
  assign rsp_rdata_o      = rdata_q;
  assign rsp_error_o      = err_q;

  always_comb begin
    state_d          = state_q;
    req_ready_o      = 1'b0;
    rsp_valid_o      = 1'b0;
    axi_mst.ar_valid = 1'b0;
    axi_mst.aw_valid = 1'b0;
    axi_mst.w_valid  = 1'b0;
    axi_mst.b_ready  = 1'b0;
    axi_mst.r_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i) begin
          if (misaligned)              state_d = ST_RSP;
          else if (req_op_i == AMO_LR) state_d = ST_AR;
          else                         state_d = ST_AW_W;
        end
      end
      ST_AR: begin
        axi_mst.ar_valid = 1'b1;
        if (axi_mst.ar_ready) state_d = ST_R_WAIT;
      end
      ST_R_WAIT: begin
        axi_mst.r_ready = 1'b1;
        if (axi_mst.r_valid) state_d = ST_RSP;
      end
      ST_AW_W: begin
        axi_mst.aw_valid = !aw_done_q;
        axi_mst.w_valid  = !w_done_q;
        if ((aw_done_q || axi_mst.aw_ready) && (w_done_q || axi_mst.w_ready))
          state_d = ST_RESP_WAIT;
      end
      ST_RESP_WAIT: begin
        axi_mst.b_ready = 1'b1;
        axi_mst.r_ready = is_amo;
        if ((b_done_q || axi_mst.b_valid) && (!is_amo || r_done_q || axi_mst.r_valid))
          state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= AMO_LR;
      addr_q    <= '0;
      size_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req_valid_i) begin
          op_q      <= req_op_i;
          addr_q    <= req_addr_aligned;
          size_q    <= req_size_i;
          wdata_q   <= req_wdata_i;
          rdata_q   <= '0;
          err_q     <= misaligned;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          b_done_q  <= 1'b0;
          r_done_q  <= 1'b0;
        end
        ST_R_WAIT: if (axi_mst.r_valid) begin
          rdata_q <= lane_rdata;
          err_q   <= resp_is_err(axi_mst.r_resp);
        end
        ST_AW_W: begin
          aw_done_q <= aw_done_q || axi_mst.aw_ready;
          w_done_q  <= w_done_q || axi_mst.w_ready;
        end
        ST_RESP_WAIT: begin
          if (b_hit) begin
            b_done_q <= 1'b1;
            if (op_q == AMO_SC)
              rdata_q <= (axi_mst.b_resp == RESP_EXOKAY) ? '0 : RiscvWordWidth'(1);
          end
          if (r_hit) begin
            r_done_q <= 1'b1;
            rdata_q  <= lane_rdata;
          end
          err_q <= err_q | (b_hit && resp_is_err(axi_mst.b_resp))
                         | (r_hit && resp_is_err(axi_mst.r_resp));
        end
        default: ;
      endcase
    end
  end
endmodule
